// File: rtl/alu_rsv_station_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_rsv_station_pkg
// Purpose : Shared widths, opcode encodings, boolean constants and the
//           reservation-station entry record for the ALU reservation station.
// Options : ALU_RS_BYPASS_EN (see alu_rsv_station.sv)
// Revision: 1.0 - initial release
// ============================================================================
package alu_rsv_station_pkg;

  localparam int DATA_W      = 32;
  localparam int ROB_ID_W    = 4;
  localparam int OP_W        = 6;
  localparam int RS_SIZE_DEF = 8;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 6'd0,
    OP_SUB = 6'd1,
    OP_AND = 6'd2,
    OP_OR  = 6'd3,
    OP_XOR = 6'd4,
    OP_SLL = 6'd5,
    OP_SRL = 6'd6,
    OP_SLT = 6'd7
  } alu_op_e;

  typedef struct packed {
    logic                valid;
    logic [OP_W-1:0]     op;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   imm;
    logic [ROB_ID_W-1:0] rob_id;
    logic                qj_wait;
    logic [ROB_ID_W-1:0] qj;
    logic [DATA_W-1:0]   vj;
    logic                qk_wait;
    logic [ROB_ID_W-1:0] qk;
    logic [DATA_W-1:0]   vk;
  } rs_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_rsv_station_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_rsv_station_if
// Purpose : Decoder issue, CDB snoop and ALU dispatch bundle of the ALU
//           reservation station. master = upstream/env side, slave = station.
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
interface alu_rsv_station_if;
  import alu_rsv_station_pkg::*;

  // decoder issue
  logic                id_valid;
  logic [OP_W-1:0]     id_op;
  logic [DATA_W-1:0]   id_pc;
  logic [DATA_W-1:0]   id_imm;
  logic [ROB_ID_W-1:0] id_rob_id;
  logic                id_qj_wait;
  logic                id_qk_wait;
  logic [ROB_ID_W-1:0] id_qj;
  logic [ROB_ID_W-1:0] id_qk;
  logic [DATA_W-1:0]   id_vj;
  logic [DATA_W-1:0]   id_vk;
  logic                rs_full;
  // common data bus
  logic                cdb_valid;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [DATA_W-1:0]   cdb_value;
  // ALU dispatch
  logic                alu_valid;
  logic [OP_W-1:0]     alu_op;
  logic [DATA_W-1:0]   alu_pc;
  logic [DATA_W-1:0]   alu_imm;
  logic [DATA_W-1:0]   alu_vj;
  logic [DATA_W-1:0]   alu_vk;
  logic [ROB_ID_W-1:0] alu_rob_id;

  modport master (
    output id_valid, id_op, id_pc, id_imm, id_rob_id,
    output id_qj_wait, id_qk_wait, id_qj, id_qk, id_vj, id_vk,
    output cdb_valid, cdb_rob_id, cdb_value,
    input  rs_full,
    input  alu_valid, alu_op, alu_pc, alu_imm, alu_vj, alu_vk, alu_rob_id
  );

  modport slave (
    input  id_valid, id_op, id_pc, id_imm, id_rob_id,
    input  id_qj_wait, id_qk_wait, id_qj, id_qk, id_vj, id_vk,
    input  cdb_valid, cdb_rob_id, cdb_value,
    output rs_full,
    output alu_valid, alu_op, alu_pc, alu_imm, alu_vj, alu_vk, alu_rob_id
  );

endinterface
`default_nettype wire

// File: rtl/alu_rs_picker.sv
`default_nettype none
// ============================================================================
// Module  : alu_rs_picker
// Purpose : Lowest-index priority encoder with a found flag. Used for both
//           free-slot search and ready-entry selection.
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
module alu_rs_picker
  import alu_rsv_station_pkg::*;
#(
  parameter int N     = RS_SIZE_DEF,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top down so the lowest requesting index wins last.
  always_comb begin
    idx   = '0;
    found = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_rsv_station.sv
`default_nettype none
// ============================================================================
// Module  : alu_rsv_station
// Purpose : ALU reservation station. Holds renamed instructions until both
//           operands are known (snooping the CDB), then dispatches the
//           lowest-index ready entry to the ALU, one per cycle.
// Options : ALU_RS_BYPASS_EN - operand-complete instructions arriving while
//           no stored entry is ready skip the entry array (1-edge latency).
// Revision: 1.0 - initial release
// ============================================================================
module alu_rsv_station
  import alu_rsv_station_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  alu_rsv_station_if.slave bus
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CNT_W = $clog2(RS_SIZE + 1);

  rs_entry_t           entries [RS_SIZE];
  logic [RS_SIZE-1:0]  free_vec;
  logic [RS_SIZE-1:0]  ready_vec;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    sel_idx;
  logic                free_found;
  logic                sel_found;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    next_count;
  logic                j_fwd, k_fwd, j_ready, k_ready;
  logic [DATA_W-1:0]   new_vj, new_vk;
  logic                accept, bypass, alloc;

  generate
    for (genvar i = 0; i < RS_SIZE; i++) begin : g_vec
      assign free_vec[i]  = ~entries[i].valid;
      assign ready_vec[i] = entries[i].valid & ~entries[i].qj_wait & ~entries[i].qk_wait;
    end
  endgenerate

  alu_rs_picker #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_pick (
    .req   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  alu_rs_picker #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_pick (
    .req   (ready_vec),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Incoming operand resolution (with same-cycle CDB forwarding) and allocation decision.
  always_comb begin
    j_fwd   = bus.cdb_valid && bus.id_qj_wait && (bus.cdb_rob_id == bus.id_qj);
    k_fwd   = bus.cdb_valid && bus.id_qk_wait && (bus.cdb_rob_id == bus.id_qk);
    j_ready = !bus.id_qj_wait || j_fwd;
    k_ready = !bus.id_qk_wait || k_fwd;
    new_vj  = j_fwd ? bus.cdb_value : bus.id_vj;
    new_vk  = k_fwd ? bus.cdb_value : bus.id_vk;
    // An issue while full is dropped; the one-slot margin keeps free_found true otherwise.
    accept  = bus.id_valid && !bus.rs_full;
`ifdef ALU_RS_BYPASS_EN
    bypass  = accept && j_ready && k_ready && !sel_found;
`else
    bypass  = FALSE;
`endif
    alloc      = accept && !bypass && free_found;
    next_count = count + CNT_W'(alloc) - CNT_W'(sel_found);
  end

  // Entry array, occupancy, full flag and registered dispatch outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) entries[i] <= '0;
      count          <= '0;
      bus.rs_full    <= FALSE;
      bus.alu_valid  <= FALSE;
      bus.alu_op     <= '0;
      bus.alu_pc     <= '0;
      bus.alu_imm    <= '0;
      bus.alu_vj     <= '0;
      bus.alu_vk     <= '0;
      bus.alu_rob_id <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < RS_SIZE; i++) entries[i].valid <= FALSE;
        count         <= '0;
        bus.rs_full   <= FALSE;
        bus.alu_valid <= FALSE;
      end else begin
        // CDB wakeup of stored entries
        for (int i = 0; i < RS_SIZE; i++) begin
          if (entries[i].valid && bus.cdb_valid) begin
            if (entries[i].qj_wait && (entries[i].qj == bus.cdb_rob_id)) begin
              entries[i].vj      <= bus.cdb_value;
              entries[i].qj_wait <= FALSE;
            end
            if (entries[i].qk_wait && (entries[i].qk == bus.cdb_rob_id)) begin
              entries[i].vk      <= bus.cdb_value;
              entries[i].qk_wait <= FALSE;
            end
          end
        end

        // Dispatch: stored ready entry first, bypass only when none is ready
        if (sel_found) begin
          bus.alu_valid              <= TRUE;
          bus.alu_op                 <= entries[sel_idx].op;
          bus.alu_pc                 <= entries[sel_idx].pc;
          bus.alu_imm                <= entries[sel_idx].imm;
          bus.alu_vj                 <= entries[sel_idx].vj;
          bus.alu_vk                 <= entries[sel_idx].vk;
          bus.alu_rob_id             <= entries[sel_idx].rob_id;
          entries[sel_idx].valid     <= FALSE;
        end else if (bypass) begin
          bus.alu_valid  <= TRUE;
          bus.alu_op     <= bus.id_op;
          bus.alu_pc     <= bus.id_pc;
          bus.alu_imm    <= bus.id_imm;
          bus.alu_vj     <= new_vj;
          bus.alu_vk     <= new_vk;
          bus.alu_rob_id <= bus.id_rob_id;
        end else begin
          bus.alu_valid  <= FALSE;
        end

        // Allocation into a slot that was already free before this edge
        if (alloc) begin
          entries[free_idx] <= '{valid:   TRUE,
                                 op:      bus.id_op,
                                 pc:      bus.id_pc,
                                 imm:     bus.id_imm,
                                 rob_id:  bus.id_rob_id,
                                 qj_wait: ~j_ready,
                                 qj:      bus.id_qj,
                                 vj:      new_vj,
                                 qk_wait: ~k_ready,
                                 qk:      bus.id_qk,
                                 vk:      new_vk};
        end

        count       <= next_count;
        bus.rs_full <= (next_count >= CNT_W'(RS_SIZE - 1));
      end
    end
  end

  // Decoder must never issue while the station reports full.
  a_no_issue_when_full: assert property (
    @(posedge clk) disable iff (rst) (rdy && !flush && bus.id_valid) |-> !bus.rs_full
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_rsv_station.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_rsv_station
// Purpose : Self-checking bench for alu_rsv_station: vector table of single
//           issues plus hand-written full/flush/freeze/back-to-back sequences,
//           with a scoreboard of expected dispatches (fields and edge number).
// Options : ALU_RS_BYPASS_EN changes the expected ready-at-issue latency.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_rsv_station;
  import alu_rsv_station_pkg::*;

`ifdef ALU_RS_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif
  localparam int PW = OP_W + 4 * DATA_W + ROB_ID_W;

  logic clk = 1'b0;
  logic rst, rdy, flush;

  alu_rsv_station_if bus ();

  alu_rsv_station #(.RS_SIZE(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string               name;
    logic [OP_W-1:0]     op;
    logic [DATA_W-1:0]   pc, imm, vj, vk;
    logic [ROB_ID_W-1:0] rob;
    int                  cyc;
  } exp_t;

  typedef struct {
    string               name;
    logic [OP_W-1:0]     op;
    logic [ROB_ID_W-1:0] rob;
    logic                qjw;
    logic [ROB_ID_W-1:0] qj;
    logic [DATA_W-1:0]   vj;
    logic                qkw;
    logic [ROB_ID_W-1:0] qk;
    logic [DATA_W-1:0]   vk;
    logic                cv;
    logic [ROB_ID_W-1:0] ct;
    logic [DATA_W-1:0]   cval;
    logic [ROB_ID_W-1:0] late_tag;
    logic [DATA_W-1:0]   late_val;
    logic [DATA_W-1:0]   ej, ek;
  } vec_t;

  exp_t sb[$];
  vec_t vt[6];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;

  function automatic logic [DATA_W-1:0] pc_of(input logic [ROB_ID_W-1:0] rob);
    return 32'h1000 + {26'd0, rob, 2'b00};
  endfunction

  function automatic logic [DATA_W-1:0] imm_of(input logic [ROB_ID_W-1:0] rob);
    return 32'hABC0 + {28'd0, rob};
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [OP_W-1:0] op, input logic [ROB_ID_W-1:0] rob,
                      input logic [DATA_W-1:0] vj, input logic [DATA_W-1:0] vk, input int cyc);
    exp_t e;
    e.name = name; e.op = op; e.pc = pc_of(rob); e.imm = imm_of(rob);
    e.vj = vj; e.vk = vk; e.rob = rob; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // One clock edge; afterwards compare any dispatch against the scoreboard.
  task automatic tick();
    logic active;
    exp_t e;
    active = rdy && !rst;
    @(posedge clk);
    #1;
    cycle++;
    if (active && bus.alu_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_dispatch: alu_valid=1 rob_id=%0d at edge %0d, required no dispatch",
                 bus.alu_rob_id, cycle);
      end else begin
        e = sb.pop_front();
        check_vec({e.name, "_fields"},
                  {bus.alu_op, bus.alu_pc, bus.alu_imm, bus.alu_vj, bus.alu_vk, bus.alu_rob_id},
                  {e.op, e.pc, e.imm, e.vj, e.vk, e.rob});
        check_int({e.name, "_edge"}, cycle, e.cyc);
      end
    end
  endtask

  task automatic idle();
    bus.id_valid  = 1'b0;
    bus.cdb_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic issue(input logic [OP_W-1:0] op, input logic [ROB_ID_W-1:0] rob,
                       input logic qjw, input logic [ROB_ID_W-1:0] qj, input logic [DATA_W-1:0] vj,
                       input logic qkw, input logic [ROB_ID_W-1:0] qk, input logic [DATA_W-1:0] vk);
    bus.id_valid   = 1'b1;
    bus.id_op      = op;
    bus.id_pc      = pc_of(rob);
    bus.id_imm     = imm_of(rob);
    bus.id_rob_id  = rob;
    bus.id_qj_wait = qjw;
    bus.id_qj      = qj;
    bus.id_vj      = vj;
    bus.id_qk_wait = qkw;
    bus.id_qk      = qk;
    bus.id_vk      = vk;
  endtask

  task automatic cdb(input logic [ROB_ID_W-1:0] tag, input logic [DATA_W-1:0] val);
    bus.cdb_valid  = 1'b1;
    bus.cdb_rob_id = tag;
    bus.cdb_value  = val;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    rdy = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    logic rdy_at_issue;
    vec_t v;

    //           name           op      rob    qjw   qj     vj            qkw   qk     vk     cv    ct     cval       ltag   lval      ej            ek
    vt[0] = '{"add_ready",    OP_ADD, 4'd3,  1'b0, 4'd0,  32'd5,        1'b0, 4'd0,  32'd7, 1'b0, 4'd0,  32'd0,     4'd0,  32'd0,    32'd5,        32'd7};
    vt[1] = '{"sub_fwd_k",    OP_SUB, 4'd5,  1'b0, 4'd0,  32'h20,       1'b1, 4'd2,  32'd0, 1'b1, 4'd2,  32'd9,     4'd0,  32'd0,    32'h20,       32'd9};
    vt[2] = '{"and_late_j",   OP_AND, 4'd7,  1'b1, 4'd6,  32'd0,        1'b0, 4'd0,  32'd1, 1'b0, 4'd0,  32'd0,     4'd6,  32'h10,   32'h10,       32'd1};
    vt[3] = '{"or_fwd_both",  OP_OR,  4'd8,  1'b1, 4'd4,  32'd0,        1'b1, 4'd4,  32'd0, 1'b1, 4'd4,  32'hAB,    4'd0,  32'd0,    32'hAB,       32'hAB};
    vt[4] = '{"xor_tag_miss", OP_XOR, 4'd9,  1'b1, 4'd10, 32'd0,        1'b0, 4'd0,  32'd3, 1'b1, 4'd11, 32'h55,    4'd10, 32'h77,   32'h77,       32'd3};
    vt[5] = '{"slt_late_k",   OP_SLT, 4'd15, 1'b0, 4'd0,  32'hFFFFFFFF, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0,  32'd0,     4'd12, 32'd1,    32'hFFFFFFFF, 32'd1};

    bus.id_op = '0; bus.id_pc = '0; bus.id_imm = '0; bus.id_rob_id = '0;
    bus.id_qj_wait = 1'b0; bus.id_qk_wait = 1'b0; bus.id_qj = '0; bus.id_qk = '0;
    bus.id_vj = '0; bus.id_vk = '0; bus.cdb_rob_id = '0; bus.cdb_value = '0;
    idle();

    // Reset applies even with rdy low.
    rst = 1'b1;
    rdy = 1'b0;
    tick();
    tick();
    check_bit("reset_alu_valid", bus.alu_valid, 1'b0);
    check_bit("reset_rs_full", bus.rs_full, 1'b0);
    check_vec("reset_alu_data",
              {bus.alu_op, bus.alu_pc, bus.alu_imm, bus.alu_vj, bus.alu_vk, bus.alu_rob_id}, '0);
    rst = 1'b0;
    rdy = 1'b1;
    tick();

    // Table of single issues: immediate, forwarded, and late-woken operands.
    for (int n = 0; n < 6; n++) begin
      v = vt[n];
      issue(v.op, v.rob, v.qjw, v.qj, v.vj, v.qkw, v.qk, v.vk);
      if (v.cv) cdb(v.ct, v.cval);
      rdy_at_issue = (!v.qjw || (v.cv && v.ct == v.qj)) && (!v.qkw || (v.cv && v.ct == v.qk));
      if (rdy_at_issue) begin
        push(v.name, v.op, v.rob, v.ej, v.ek, cycle + 1 + LAT);
        tick();
        idle();
      end else begin
        tick();
        idle();
        repeat (4) tick();
        cdb(v.late_tag, v.late_val);
        push(v.name, v.op, v.rob, v.ej, v.ek, cycle + 2);
        tick();
        idle();
      end
      repeat (3) tick();
      check_int({v.name, "_drained"}, sb.size(), 0);
    end

    // Fill to the full threshold, then wake and drain in index order.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      issue(OP_ADD, 4'(i), 1'b1, (i < 6) ? 4'(i + 1) : 4'd6, 32'd0, 1'b0, 4'd0, 32'(100 + i));
      tick();
      check_bit($sformatf("full_after_issue%0d", i), bus.rs_full, (i >= 6));
    end
    idle();
    for (int t = 1; t <= 6; t++) begin
      cdb(4'(t), 32'(t * 16));
      push($sformatf("drain%0d", t - 1), OP_ADD, 4'(t - 1), 32'(t * 16), 32'(100 + t - 1), cycle + 2);
      if (t == 6) push("drain6", OP_ADD, 4'd6, 32'd96, 32'd106, cycle + 3);
      tick();
      if (t == 1) check_bit("full_after_wake", bus.rs_full, 1'b1);
      if (t == 2) check_bit("full_after_dispatch", bus.rs_full, 1'b0);
    end
    idle();
    repeat (4) tick();
    check_int("drain_done", sb.size(), 0);

    // Flush with issue and CDB in the same cycle; later wakeups must not dispatch.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      issue(OP_OR, 4'(i + 8), 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'(i));
      tick();
    end
    check_bit("prefl_rs_full", bus.rs_full, 1'b1);
    flush = 1'b1;
    issue(OP_ADD, 4'd12, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
    cdb(4'd9, 32'h99);
    tick();
    check_bit("flush_alu_valid", bus.alu_valid, 1'b0);
    check_bit("flush_rs_full", bus.rs_full, 1'b0);
    idle();
    tick();
    cdb(4'd9, 32'h99);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bit($sformatf("postfl_no_dispatch%0d", i), bus.alu_valid, 1'b0);
    end
    issue(OP_AND, 4'd13, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd4);
    push("postfl_issue", OP_AND, 4'd13, 32'd3, 32'd4, cycle + 1 + LAT);
    tick();
    idle();
    repeat (2) tick();
    for (int i = 0; i < 6; i++) begin
      issue(OP_SUB, 4'(i), 1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'd0);
      tick();
    end
    idle();
    check_bit("postfl_count_reset", bus.rs_full, 1'b0);
    flush = 1'b1;
    tick();
    idle();
    tick();
    check_int("flush_done", sb.size(), 0);

    // rdy low freezes everything and ignores inputs.
    do_reset();
    issue(OP_XOR, 4'd4, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h22);
    push("freeze", OP_XOR, 4'd4, 32'h11, 32'h22, cycle + 1 + ((LAT == 1) ? 4 : 0));
    tick();
    rdy = 1'b0;
    issue(OP_SUB, 4'd9, 1'b0, 4'd0, 32'h33, 1'b0, 4'd0, 32'h44);
    cdb(4'd2, 32'h5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bit($sformatf("freeze_valid%0d", i), bus.alu_valid, (LAT == 0));
      check_int($sformatf("freeze_rob%0d", i), int'(bus.alu_rob_id), (LAT == 0) ? 4 : 0);
    end
    rdy = 1'b1;
    idle();
    repeat (4) tick();
    check_int("freeze_done", sb.size(), 0);

    // Back-to-back ready issues: allocate and dispatch on the same edge.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(OP_SLL, 4'(i + 1), 1'b0, 4'd0, 32'(i), 1'b0, 4'd0, 32'(i + 10));
      push($sformatf("b2b%0d", i), OP_SLL, 4'(i + 1), 32'(i), 32'(i + 10), cycle + 1 + LAT);
      tick();
    end
    idle();
    repeat (3) tick();
    check_int("b2b_done", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
